// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_resp_pkg;

  localparam int unsigned DefAddrW      = 16;
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefDepth      = 256;
  localparam int unsigned DefWaitCycles = 2;
  localparam int unsigned MaxWaitCycles = 15;
  // Wide enough to hold any wait-state count up to MaxWaitCycles.
  localparam int unsigned CntW          = $clog2(16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_resp_ram.sv
// Storage array for mem_responder: synchronous write, combinational read, no reset.
module mem_resp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit writes on the rising edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder. Accepts one read/write at a time, inserts WAIT_CYCLES
// wait states, then completes. Define MEM_RESP_RANGE_CHECK_EN to reject addresses >= DEPTH;
// otherwise storage is indexed with the address modulo DEPTH.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LoadInt = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] CntLoad = CntW'(LoadInt);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              is_wr_q;
  logic              rvalid_q;
  logic              busy_q;
  logic              err_q;

  logic              is_idle;
  logic              req;
  logic              proto_err;
  logic              oor;
  logic              ram_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] resp_data;

  assign is_idle = (state_q == S_IDLE);
  assign req     = i_mem_rd | i_mem_wr;
  // The response is prepared on the edge entering S_RESP; with zero wait states that edge
  // is the accepting one, so the live address is used while idle.
  assign rd_addr = is_idle ? i_addr : addr_q;

`ifdef MEM_RESP_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);
  assign oor = ({1'b0, rd_addr} >= DepthExt);
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^rd_addr;
`endif

  assign resp_data = oor ? '0 : ram_rdata;
  assign ram_we    = (state_q == S_RESP) & is_wr_q & ~oor;

  // Conflicting strobes while idle, or any strobe while busy, flag a protocol error.
  assign proto_err = is_idle ? (i_mem_rd & i_mem_wr) : req;

  mem_resp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (addr_q[IdxW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (rd_addr[IdxW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Request FSM with registered completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      is_wr_q  <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            is_wr_q <= i_mem_wr;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q  <= S_RESP;
              rvalid_q <= ~i_mem_wr;
              err_q    <= oor;
              if (!i_mem_wr) rdata_q <= resp_data;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CntLoad;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= S_RESP;
            rvalid_q <= ~is_wr_q;
            err_q    <= oor;
            if (!is_wr_q) rdata_q <= resp_data;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_busy   = busy_q;
  // Gated by reset so the error pulse is quiet while reset is held.
  assign o_err    = rst & (err_q | proto_err);

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: one instance with two wait states,
// one with zero wait states.
module tb_mem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rvalid;
    logic [15:0] rdata;
    logic        busy;
    logic        err;
  } vec_t;

`ifdef MEM_RESP_RANGE_CHECK_EN
  localparam logic [15:0] RangeRdata = 16'h0000;
  localparam logic        RangeErr   = 1'b1;
`else
  localparam logic [15:0] RangeRdata = 16'hC0DE;
  localparam logic        RangeErr   = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rd2, wr2, rvalid2, busy2, err2;
  logic [15:0] addr2, wdata2, rdata2;
  logic        rst0, rd0, wr0, rvalid0, busy0, err0;
  logic [15:0] addr0, wdata0, rdata0;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .i_mem_rd(rd2), .i_mem_wr(wr2), .i_addr(addr2),
    .i_wdata(wdata2), .o_rdata(rdata2), .o_rvalid(rvalid2), .o_busy(busy2), .o_err(err2)
  );

  mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .i_mem_rd(rd0), .i_mem_wr(wr0), .i_addr(addr0),
    .i_wdata(wdata0), .o_rdata(rdata0), .o_rvalid(rvalid0), .o_busy(busy0), .o_err(err0)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic rvalid,
                             input logic [15:0] rdata, input logic busy, input logic err);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
    r.rvalid = rvalid; r.rdata = rdata; r.busy = busy; r.err = err;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the rising edge.
  task automatic step(input bit sel0, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata);
    @(posedge clk);
    #1;
    if (sel0) begin
      rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = addr; wdata2 = wdata;
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Cycle-by-cycle expectations for the WAIT_CYCLES=2 instance.
    // Write 0x1234 @0x05, read it back at cycle 4 -> rvalid at cycle 7.
    vecs.push_back(v(0, 1, 16'h0005, 16'h1234, 0, 16'h0000, 0, 0));  // 0 accept
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));  // 1 wait
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));  // 2 wait
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));  // 3 resp (commit)
    vecs.push_back(v(1, 0, 16'h0005, 16'h0000, 0, 16'h0000, 0, 0));  // 4 read accept
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));  // 5
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0));  // 6
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1, 0));  // 7 rvalid
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0));  // 8
    // Read, then re-strobe while busy; also strobe during S_RESP.
    vecs.push_back(v(1, 0, 16'h0005, 16'h0000, 0, 16'h1234, 0, 0));  // 9 accept
    vecs.push_back(v(1, 0, 16'h0005, 16'h0000, 0, 16'h1234, 1, 1));  // 10 ignored, err
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 11
    vecs.push_back(v(1, 0, 16'h0005, 16'h0000, 1, 16'h1234, 1, 1));  // 12 resp + ignored
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0));  // 13 idle, nothing pending
    // Simultaneous rd+wr treated as a write with an error pulse.
    vecs.push_back(v(1, 1, 16'h0002, 16'h00AA, 0, 16'h1234, 0, 1));  // 14
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 15
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 16
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 17 resp, no rvalid
    vecs.push_back(v(1, 0, 16'h0002, 16'h0000, 0, 16'h1234, 0, 0));  // 18
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 19
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0));  // 20
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 1, 16'h00AA, 1, 0));  // 21
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 0, 0));  // 22
    // Out-of-range read of 0x0100 against known contents of 0x00.
    vecs.push_back(v(0, 1, 16'h0000, 16'hC0DE, 0, 16'h00AA, 0, 0));  // 23
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 1, 0));  // 24
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 1, 0));  // 25
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 1, 0));  // 26
    vecs.push_back(v(1, 0, 16'h0100, 16'h0000, 0, 16'h00AA, 0, 0));  // 27
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 1, 0));  // 28
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 16'h00AA, 1, 0));  // 29
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 1, RangeRdata, 1, RangeErr));  // 30
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, RangeRdata, 0, 0));  // 31

    rst2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
    rst0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    #2;
    check("reset rdata", rdata2, 16'h0000);
    check("reset rvalid", {15'd0, rvalid2}, 16'd0);
    check("reset busy", {15'd0, busy2}, 16'd0);
    check("reset err", {15'd0, err2}, 16'd0);
    @(negedge clk);
    rst2 = 1'b1;
    rst0 = 1'b1;

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("row%0d rvalid", i), {15'd0, rvalid2}, {15'd0, vecs[i].rvalid});
      check($sformatf("row%0d rdata", i), rdata2, vecs[i].rdata);
      check($sformatf("row%0d busy", i), {15'd0, busy2}, {15'd0, vecs[i].busy});
      check($sformatf("row%0d err", i), {15'd0, err2}, {15'd0, vecs[i].err});
    end

    // Reset during S_WAIT aborts the pending write.
    step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("abort pre busy", {15'd0, busy2}, 16'd1);
    #1;
    rst2 = 1'b0;
    #1;
    check("abort rdata", rdata2, 16'h0000);
    check("abort rvalid", {15'd0, rvalid2}, 16'd0);
    check("abort busy", {15'd0, busy2}, 16'd0);
    check("abort err", {15'd0, err2}, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("abort readback rvalid", {15'd0, rvalid2}, 16'd1);
    check("abort readback rdata", rdata2, 16'h1111);

    // Zero wait states: write 0xBEEF @0x10, read it back with one-cycle latency.
    step(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    check("w0 accept busy", {15'd0, busy0}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("w0 resp busy", {15'd0, busy0}, 16'd1);
    check("w0 resp rvalid", {15'd0, rvalid0}, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("w0 rd accept rvalid", {15'd0, rvalid0}, 16'd0);
    check("w0 rd accept busy", {15'd0, busy0}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("w0 rvalid", {15'd0, rvalid0}, 16'd1);
    check("w0 rdata", rdata0, 16'hBEEF);
    check("w0 busy", {15'd0, busy0}, 16'd1);
    check("w0 err", {15'd0, err0}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("w0 after busy", {15'd0, busy0}, 16'd0);
    check("w0 after rvalid", {15'd0, rvalid0}, 16'd0);
    check("w0 held rdata", rdata0, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
